// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with start/parity/stop checking and a FWFT receive FIFO
//
// Purpose:
//   Receives asynchronous serial frames (1 start bit, DATA_BITS data bits LSB
//   first, optional parity bit, 1 stop bit) and buffers good words in a
//   first-word-fall-through FIFO so the consumer can pop at its own pace.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rx           serial input, idle high, asynchronous to clk
//   rd_en        pop request, honoured only while rd_valid is high
//   rd_data      FIFO head word (valid while rd_valid is high)
//   rd_valid     FIFO not empty
//   fifo_full    FIFO holds FIFO_DEPTH words
//   busy         receiver is in the middle of a frame (or waiting out a break)
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch with a good stop bit
//   overrun_err  one-cycle pulse: good word dropped because the FIFO was full

module uart_rx_fifo #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 fifo_full,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    // Bit period rounded to the nearest clock, and the mid-bit offset used
    // to land every sample in the centre of its bit.
    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchroniser plus one more flop for
    // falling-edge detection. All reset high so reset never looks like
    // a start bit.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 par_expect;
    logic                 push_pend;

    // Even parity: parity bit equals the XOR of the data; odd inverts it.
    assign par_expect = (^shreg) ^ (PARITY == 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            push_pend  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            push_pend  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_fall) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end

                // Re-check the line at mid start bit; a high level means the
                // falling edge was a glitch and the frame is abandoned.
                S_START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                        state   <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == DIV_END) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt == DIV_END) begin
                        cnt     <= '0;
                        par_bad <= (rx_sync != par_expect);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Returning to IDLE straight from the stop sample re-arms the
                // edge detector in time for a back-to-back start bit. The word
                // stays in shreg for the push cycle that follows, since no new
                // data bit can arrive for at least half a bit period.
                S_STOP: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            push_pend <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // A line held low must return high before a new frame can
                // start, otherwise it would be re-read as endless zero frames.
                S_BREAK: begin
                    if (rx_sync) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO: pointers carry one extra wrap bit so full and empty
    // are distinguishable without an occupancy counter.
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wrptr;
    logic [AW:0]          rdptr;
    logic                 empty;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (wrptr == rdptr);
    assign full  = (wrptr[AW-1:0] == rdptr[AW-1:0]) && (wrptr[AW] != rdptr[AW]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    // the word; the write lands on the head slot being released.
    assign do_pop      = rd_en & ~empty;
    assign do_push     = push_pend & (~full | do_pop);
    assign overrun_err = push_pend & full & ~rd_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrptr <= '0;
            rdptr <= '0;
        end else begin
            if (do_push) begin
                wrptr <= wrptr + 1'b1;
            end
            if (do_pop) begin
                rdptr <= rdptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wrptr[AW-1:0]] <= shreg;
        end
    end

    assign rd_data   = mem[rdptr[AW-1:0]];
    assign rd_valid  = ~empty;
    assign fifo_full = full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 7E1 instances)

module tb_uart_rx_fifo;

    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx0, rx1, rd_en0, rd_en1;
    logic [7:0] rd_data0;
    logic [6:0] rd_data1;
    logic       rd_valid0, fifo_full0, busy0, frame_err0, parity_err0, overrun_err0;
    logic       rd_valid1, fifo_full1, busy1, frame_err1, parity_err1, overrun_err1;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset_n(reset_n), .rx(rx0), .rd_en(rd_en0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .fifo_full(fifo_full0), .busy(busy0), .frame_err(frame_err0),
        .parity_err(parity_err0), .overrun_err(overrun_err0)
    );

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .rx(rx1), .rd_en(rd_en1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .fifo_full(fifo_full1), .busy(busy1), .frame_err(frame_err1),
        .parity_err(parity_err1), .overrun_err(overrun_err1)
    );

    int checks = 0;
    int errors = 0;

    // Pulse counters, sampled late in each cycle (after the stimulus edge).
    int fe0 = 0, pe0 = 0, oe0 = 0, bz0 = 0;
    int fe1 = 0, pe1 = 0, oe1 = 0;

    always @(negedge clk) begin
        #3;
        if (frame_err0)   fe0++;
        if (parity_err0)  pe0++;
        if (overrun_err0) oe0++;
        if (busy0)        bz0++;
        if (frame_err1)   fe1++;
        if (parity_err1)  pe1++;
        if (overrun_err1) oe1++;
    end

    int q0[$];
    int q1[$];
    int exp_oe0, exp_oe1, exp_pe1;
    int s_fe0, s_pe0, s_oe0, s_bz0, s_fe1, s_pe1, s_oe1;
    int lat, d, bad, k, n;
    logic got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int u, input logic b);
        if (u == 0) rx0 = b;
        else        rx1 = b;
    endtask

    task automatic bit_time(input int u, input logic b, input int nb);
        set_rx(u, b);
        repeat (nb * DIV) @(negedge clk);
    endtask

    task automatic send_body(input int u, input int data, input int nbits, input int par);
        logic [8:0] dv;
        dv = data[8:0];
        bit_time(u, 1'b0, 1);
        for (int i = 0; i < nbits; i++) bit_time(u, dv[i], 1);
        if (par >= 0) bit_time(u, par[0], 1);
    endtask

    task automatic send(input int u, input int data, input int nbits, input int par, input int stop_low);
        send_body(u, data, nbits, par);
        if (stop_low > 0) bit_time(u, 1'b0, stop_low);
        bit_time(u, 1'b1, 1);
    endtask

    task automatic pop(input int u, input int exp, input string tag);
        if (u == 0) begin
            check({tag, "_valid"}, rd_valid0, 1);
            check({tag, "_data"}, rd_data0, exp);
            rd_en0 = 1'b1;
            @(negedge clk);
            rd_en0 = 1'b0;
        end else begin
            check({tag, "_valid"}, rd_valid1, 1);
            check({tag, "_data"}, rd_data1, exp);
            rd_en1 = 1'b1;
            @(negedge clk);
            rd_en1 = 1'b0;
        end
    endtask

    task automatic snap();
        s_fe0 = fe0; s_pe0 = pe0; s_oe0 = oe0; s_bz0 = bz0;
        s_fe1 = fe1; s_pe1 = pe1; s_oe1 = oe1;
    endtask

    initial begin
        reset_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rd_en0 = 1'b0; rd_en1 = 1'b0;
        exp_oe0 = 0; exp_oe1 = 0; exp_pe1 = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rd_valid0", rd_valid0, 0);
        check("rst_fifo_full0", fifo_full0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_rd_data0", rd_data0, 0);
        check("rst_errs0", {frame_err0, parity_err0, overrun_err0}, 0);
        check("rst_rd_valid1", rd_valid1, 0);
        check("rst_busy1", busy1, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back 8N1 frames, first-word latency
        snap();
        lat = 0;
        fork
            begin
                send(0, 'h55, 8, -1, 0);
                send(0, 'hA3, 8, -1, 0);
            end
            begin
                while (!rd_valid0 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        // sync + detect (3) + start sample (HALF) + 9 bit periods + push cycle
        n = 3 + HALF + 9 * DIV + 1;
        check("b2b_latency_window", (lat >= n - 2 && lat <= n + 2), 1);
        pop(0, 'h55, "b2b_pop0");
        pop(0, 'hA3, "b2b_pop1");
        check("b2b_empty", rd_valid0, 0);
        check("b2b_no_errs", (fe0 - s_fe0) + (pe0 - s_pe0) + (oe0 - s_oe0), 0);

        // Short low glitch on idle line
        snap();
        rx0 = 1'b0;
        repeat (HALF - 3) @(negedge clk);
        rx0 = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_busy_seen", (bz0 > s_bz0), 1);
        check("glitch_idle", busy0, 0);
        check("glitch_no_word", rd_valid0, 0);
        check("glitch_no_errs", (fe0 - s_fe0) + (pe0 - s_pe0) + (oe0 - s_oe0), 0);

        // Stop bit held low for 3 bit times -> break
        snap();
        send_body(0, 'h3C, 8, -1);
        bit_time(0, 1'b0, 3);
        check("break_busy", busy0, 1);
        check("break_frame_err", fe0 - s_fe0, 1);
        check("break_no_word", rd_valid0, 0);
        bit_time(0, 1'b1, 1);
        check("break_released", busy0, 0);
        send(0, 'h01, 8, -1, 0);
        pop(0, 'h01, "break_next");
        check("break_single_pulse", fe0 - s_fe0, 1);

        // Randomized 8N1 traffic with random reads, reference queue model
        snap();
        exp_oe0 = 0;
        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 255);
            send(0, d, 8, -1, 0);
            if (q0.size() < DEPTH) q0.push_back(d);
            else exp_oe0++;
            check("rand_full", fifo_full0, (q0.size() == DEPTH));
            k = $urandom_range(0, q0.size());
            for (int j = 0; j < k; j++) pop(0, q0.pop_front(), "rand_pop");
        end
        while (q0.size() > 0) pop(0, q0.pop_front(), "rand_drain");
        check("rand_empty", rd_valid0, 0);
        check("rand_overruns", oe0 - s_oe0, exp_oe0);
        check("rand_no_frame_err", fe0 - s_fe0, 0);

        // FIFO fill and overrun
        snap();
        for (int i = 0; i < 4; i++) begin
            send(0, 'h10 + i, 8, -1, 0);
            check("fill_full", fifo_full0, (i == 3));
        end
        send(0, 'h14, 8, -1, 0);
        check("fill_overrun", oe0 - s_oe0, 1);
        for (int i = 0; i < 4; i++) pop(0, 'h10 + i, "fill_pop");
        check("fill_empty", rd_valid0, 0);

        // Full FIFO with a pop in the push cycle: word accepted, no overrun
        snap();
        for (int i = 0; i < 4; i++) send(0, 'h20 + i, 8, -1, 0);
        got = 1'b0;
        fork
            send(0, 'h24, 8, -1, 0);
            begin
                n = 0;
                while (!busy0 && n < 400) begin @(negedge clk); n++; end
                while (busy0 && n < 800) begin @(negedge clk); n++; end
                if (!busy0) begin
                    check("pushpop_head", rd_data0, 'h20);
                    rd_en0 = 1'b1;
                    got = 1'b1;
                    @(negedge clk);
                    rd_en0 = 1'b0;
                end
            end
        join
        check("pushpop_reached", got, 1);
        check("pushpop_no_overrun", oe0 - s_oe0, 0);
        check("pushpop_still_full", fifo_full0, 1);
        for (int i = 1; i < 5; i++) pop(0, 'h20 + i, "pushpop_pop");
        check("pushpop_empty", rd_valid0, 0);

        // 7E1: wrong parity, then correct parity, then frame error precedence
        snap();
        d = 'h41;
        send(1, d, 7, ($countones(d) % 2) ^ 1, 0);
        check("par_bad_pulse", pe1 - s_pe1, 1);
        check("par_bad_no_word", rd_valid1, 0);
        send(1, d, 7, $countones(d) % 2, 0);
        pop(1, 'h41, "par_good");
        send(1, d, 7, ($countones(d) % 2) ^ 1, 1);
        check("prec_frame_err", fe1 - s_fe1, 1);
        check("prec_no_parity_err", pe1 - s_pe1, 1);
        check("prec_no_word", rd_valid1, 0);

        // Randomized 7E1 traffic with random parity corruption
        snap();
        exp_pe1 = 0; exp_oe1 = 0;
        for (int i = 0; i < 20; i++) begin
            d = $urandom_range(0, 127);
            bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
            send(1, d, 7, ($countones(d) % 2) ^ bad, 0);
            if (bad != 0) exp_pe1++;
            else if (q1.size() < DEPTH) q1.push_back(d);
            else exp_oe1++;
            k = $urandom_range(0, q1.size());
            for (int j = 0; j < k; j++) pop(1, q1.pop_front(), "rand7_pop");
        end
        while (q1.size() > 0) pop(1, q1.pop_front(), "rand7_drain");
        check("rand7_parity_errs", pe1 - s_pe1, exp_pe1);
        check("rand7_overruns", oe1 - s_oe1, exp_oe1);
        check("rand7_empty", rd_valid1, 0);

        // Reset in the middle of bit 4 with two words buffered
        send(0, 'h11, 8, -1, 0);
        send(0, 'h22, 8, -1, 0);
        check("mid_rst_buffered", rd_valid0, 1);
        d = 'h5A;
        bit_time(0, 1'b0, 1);
        for (int i = 0; i < 4; i++) bit_time(0, d[i], 1);
        set_rx(0, d[4]);
        repeat (HALF) @(negedge clk);
        reset_n = 1'b0;
        rx0 = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", rd_valid0, 0);
        check("mid_rst_full", fifo_full0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_data", rd_data0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send(0, 'h7E, 8, -1, 0);
        pop(0, 'h7E, "mid_rst_frame");
        check("mid_rst_only_entry", rd_valid0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
